// File: rtl/sig_dump_ctrl_if.sv
// Signal bundle for sig_dump_ctrl: register slave port, memory read master port,
// signature word stream and status flags.
interface sig_dump_ctrl_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        sig_valid_o;
  logic [31:0] sig_data_o;
  logic        sig_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [30:0] exit_code_o;

  modport slave (
    input  we_i, addr_i, data_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, sig_ready_i,
    output data_o, mem_req_o, mem_addr_o, sig_valid_o, sig_data_o,
           busy_o, done_o, err_o, exit_code_o
  );

  modport master (
    output we_i, addr_i, data_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, sig_ready_i,
    input  data_o, mem_req_o, mem_addr_o, sig_valid_o, sig_data_o,
           busy_o, done_o, err_o, exit_code_o
  );
endinterface

// File: rtl/sig_dump_ctrl.sv
// End-of-test signature dump controller: walks a firmware-programmed address range
// through a read master port and streams each word out, then reports done/err.
module sig_dump_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic           clk,
  input  logic           rst,
  sig_dump_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PUSH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

  state_t           state_r, state_nxt_s;
  logic [31:0]      begin_r, end_r, ptr_r, ptr_nxt_s;
  logic [31:0]      mem_addr_r, mem_addr_nxt_s, sig_data_r;
  logic [30:0]      exit_code_r;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [TO_W-1:0]  to_cnt_r;
  logic             mem_req_r, sig_valid_r, busy_r, done_r, err_r;
  logic             mem_req_nxt_s, sig_valid_nxt_s, busy_nxt_s, done_nxt_s, err_nxt_s;
  logic             idle_s, wr_begin_s, wr_end_s, wr_exit_s, start_s;
  logic             empty_range_s, accept_s, last_word_s, timeout_s;
  logic [32:0]      ptr_inc_s;
  logic [31:0]      status_s, rd_data_s;
  logic             unused_s;

  // Undecoded address bits
  assign unused_s = ^{bus.addr_i[31:4], bus.addr_i[1:0]};

  // Register-write decode and datapath conditions; config writes only land when not dumping
  always_comb begin
    idle_s        = (state_r == S_IDLE) || (state_r == S_DONE);
    wr_begin_s    = bus.we_i && (bus.addr_i[3:2] == 2'd0) && idle_s;
    wr_end_s      = bus.we_i && (bus.addr_i[3:2] == 2'd1) && idle_s;
    wr_exit_s     = bus.we_i && (bus.addr_i[3:2] == 2'd2) && idle_s;
    start_s       = wr_exit_s && bus.data_i[0];
    empty_range_s = (begin_r >= end_r);
    accept_s      = (state_r == S_PUSH) && bus.sig_ready_i;
    // The 33rd bit catches a pointer wrap past the top of the address space
    ptr_inc_s     = {1'b0, ptr_r} + 33'd4;
    last_word_s   = ptr_inc_s[32] || (ptr_inc_s[31:0] >= end_r) || (count_r == CNT_LAST);
    timeout_s     = (state_r == S_WAIT) && !bus.mem_rvalid_i && (to_cnt_r == TO_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_s) begin
          state_nxt_s = empty_range_s ? S_DONE : S_REQ;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_REQ: begin
        if (bus.mem_gnt_i) begin
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid_i) begin
          state_nxt_s = S_PUSH;
        end else if (timeout_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_PUSH: begin
        if (accept_s) begin
          state_nxt_s = last_word_s ? S_DONE : S_REQ;
        end else begin
          state_nxt_s = S_PUSH;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output and pointer next values, decoded from the next state so outputs can be registered
  always_comb begin
    if (start_s) begin
      ptr_nxt_s = begin_r;
    end else if (accept_s) begin
      ptr_nxt_s = ptr_inc_s[31:0];
    end else begin
      ptr_nxt_s = ptr_r;
    end
    if (start_s) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (accept_s && (count_r != CNT_MAX)) begin
      count_nxt_s = count_r + CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    if (start_s) begin
      err_nxt_s = 1'b0;
    end else if (timeout_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
    mem_req_nxt_s   = (state_nxt_s == S_REQ);
    mem_addr_nxt_s  = mem_req_nxt_s ? ptr_nxt_s : 32'd0;
    sig_valid_nxt_s = (state_nxt_s == S_PUSH);
    busy_nxt_s      = (state_nxt_s == S_REQ) || (state_nxt_s == S_WAIT) || (state_nxt_s == S_PUSH);
    done_nxt_s      = (state_nxt_s == S_DONE);
  end

  // Registered handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'd0;
      sig_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      sig_valid_r <= sig_valid_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  // Config registers, walk pointer, word counter, timeout counter and captured read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      begin_r     <= 32'd0;
      end_r       <= 32'd0;
      exit_code_r <= 31'd0;
      ptr_r       <= 32'd0;
      count_r     <= {CNT_W{1'b0}};
      to_cnt_r    <= {TO_W{1'b0}};
      sig_data_r  <= 32'd0;
    end else begin
      if (wr_begin_s) begin
        begin_r <= {bus.data_i[31:2], 2'b00};
      end
      if (wr_end_s) begin
        end_r <= {bus.data_i[31:2], 2'b00};
      end
      if (wr_exit_s) begin
        exit_code_r <= bus.data_i[31:1];
      end
      ptr_r   <= ptr_nxt_s;
      count_r <= count_nxt_s;
      if (state_r == S_REQ) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else if (state_r == S_WAIT) begin
        to_cnt_r <= to_cnt_r + TO_ONE;
      end
      if ((state_r == S_WAIT) && bus.mem_rvalid_i) begin
        sig_data_r <= bus.mem_rdata_i;
      end
    end
  end

  // Slave read mux; the count field is zero-extended into the upper half of STATUS
  always_comb begin
    status_s = {16'(count_r), 13'd0, err_r, done_r, busy_r};
    case (bus.addr_i[3:2])
      2'd0:    rd_data_s = begin_r;
      2'd1:    rd_data_s = end_r;
      2'd2:    rd_data_s = 32'd0;
      2'd3:    rd_data_s = status_s;
      default: rd_data_s = 32'd0;
    endcase
  end

  assign bus.data_o      = rd_data_s;
  assign bus.mem_req_o   = mem_req_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.sig_valid_o = sig_valid_r;
  assign bus.sig_data_o  = sig_data_r;
  assign bus.busy_o      = busy_r;
  assign bus.done_o      = done_r;
  assign bus.err_o       = err_r;
  assign bus.exit_code_o = exit_code_r;

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Self-checking bench for sig_dump_ctrl: scoreboarded memory-read addresses and
// streamed signature words, plus per-scenario status checks.
module tb_sig_dump_ctrl;
  localparam int unsigned TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sig_dump_ctrl_if bus();

  sig_dump_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem_model [logic [31:0]];
  bit          mem_resp_en = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    else return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: grant as soon as a request is seen, return data one cycle after grant
  initial begin : mem_responder
    logic        fire;
    logic [31:0] faddr, ea;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'd0;
    forever begin
      @(negedge clk);
      fire  = !rst && bus.mem_req_o && bus.mem_gnt_i;
      faddr = bus.mem_addr_o;
      if (fire) begin
        checks++;
        if (addr_q.size() == 0) begin
          failures++; $display("FAIL mem_addr_extra: got request at %h, none expected", faddr);
        end else begin
          ea = addr_q.pop_front();
          if (faddr !== ea) begin failures++; $display("FAIL mem_addr: got %h want %h", faddr, ea); end
        end
      end
      @(posedge clk); #1;
      bus.mem_rvalid_i = fire && mem_resp_en && !rst;
      bus.mem_rdata_i  = fire ? mem_word(faddr) : 32'd0;
      bus.mem_gnt_i    = bus.mem_req_o;
    end
  end

  // Stream monitor: every accepted word is popped from the scoreboard
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (!rst && bus.sig_valid_o && bus.sig_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL sig_word_extra: got %h, none expected", bus.sig_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.sig_data_o !== mon_exp) begin
          failures++; $display("FAIL sig_word: got %h want %h", bus.sig_data_o, mon_exp);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    bus.we_i = 1'b1; bus.addr_i = {28'd0, idx, 2'b00}; bus.data_i = d;
    @(posedge clk); #1;
    bus.we_i = 1'b0; bus.data_i = 32'd0;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] d);
    bus.addr_i = {28'd0, idx, 2'b00};
    #1 d = bus.data_o;
    @(posedge clk); #1;
  endtask

  task automatic push_range(input logic [31:0] b, input logic [31:0] e);
    for (logic [31:0] p = b; p < e; p = p + 32'd4) begin
      exp_q.push_back(mem_word(p));
      addr_q.push_back(p);
    end
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    ok = 1'b0; cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.done_o === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.sig_valid_o === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      failures++; $display("FAIL %s_drained: got %0d words %0d addrs left, want 0 0", tag, exp_q.size(), addr_q.size());
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.we_i = 1'b0; bus.addr_i = 32'd0; bus.data_i = 32'd0; bus.sig_ready_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.mem_req_o, bus.sig_valid_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 00000", {bus.mem_req_o, bus.sig_valid_o, bus.busy_o, bus.done_o, bus.err_o});
    end
    checks++;
    if (bus.exit_code_o !== 31'd0 || bus.sig_data_o !== 32'd0 || bus.mem_addr_o !== 32'd0) begin
      failures++; $display("FAIL reset_data: got exit %h sig %h addr %h want 0", bus.exit_code_o, bus.sig_data_o, bus.mem_addr_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rd(2'd3, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_status: got %h want 0", d); end
    rd(2'd1, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_end: got %h want 0", d); end
  endtask

  task automatic test_basic_dump();
    logic [31:0] d; int cyc; bit ok;
    mem_model[32'h100] = 32'hA; mem_model[32'h104] = 32'hB; mem_model[32'h108] = 32'hC;
    wr(2'd0, 32'h100);
    wr(2'd1, 32'h10F);
    rd(2'd1, d);
    checks++; if (d !== 32'h10C) begin failures++; $display("FAIL end_low_bits: got %h want 0000010c", d); end
    push_range(32'h100, 32'h10C);
    wr(2'd2, 32'h3);
    wait_done(50, cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done: got done=%b want 1", bus.done_o); end
    checks++; if (cyc != 9) begin failures++; $display("FAIL basic_latency: got %0d cycles want 9", cyc); end
    checks++;
    if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.exit_code_o !== 31'd1) begin
      failures++; $display("FAIL basic_flags: got err %b busy %b exit %h want 0 0 1", bus.err_o, bus.busy_o, bus.exit_code_o);
    end
    rd(2'd3, d);
    checks++; if (d !== 32'h0003_0002) begin failures++; $display("FAIL basic_status: got %h want 00030002", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL exit_read: got %h want 0", d); end
    check_drained("basic");
  endtask

  task automatic test_empty_range();
    logic [31:0] d; bit req_seen;
    wr(2'd0, 32'h200);
    wr(2'd1, 32'h200);
    wr(2'd2, 32'h11);
    req_seen = bus.mem_req_o;
    checks++;
    if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL empty_done: got done %b busy %b want 1 0", bus.done_o, bus.busy_o);
    end
    @(posedge clk); #1;
    req_seen = req_seen | bus.mem_req_o;
    checks++; if (req_seen !== 1'b0) begin failures++; $display("FAIL empty_no_req: got req %b want 0", req_seen); end
    rd(2'd3, d);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL empty_status: got %h want 00000002", d); end
    checks++; if (bus.exit_code_o !== 31'd8) begin failures++; $display("FAIL empty_exit: got %h want 8", bus.exit_code_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, held; int cyc; bit ok, bad;
    wr(2'd0, 32'h300);
    wr(2'd1, 32'h308);
    bus.sig_ready_i = 1'b0;
    push_range(32'h300, 32'h308);
    wr(2'd2, 32'h1);
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      failures++; $display("FAIL restart_clear: got done %b busy %b want 0 1", bus.done_o, bus.busy_o);
    end
    wait_valid(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_valid: got valid=%b want 1", bus.sig_valid_o); end
    held = bus.sig_data_o;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.sig_valid_o !== 1'b1 || bus.sig_data_o !== held || bus.mem_req_o !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL bp_hold: got data %h valid %b req %b want stable", bus.sig_data_o, bus.sig_valid_o, bus.mem_req_o); end
    bus.sig_ready_i = 1'b1;
    wait_done(50, cyc, ok);
    rd(2'd3, d);
    checks++; if (d !== 32'h0002_0002) begin failures++; $display("FAIL bp_status: got %h want 00020002", d); end
    check_drained("bp");
  endtask

  task automatic test_timeout();
    logic [31:0] d; int cyc; bit ok;
    mem_resp_en = 1'b0;
    wr(2'd0, 32'h400);
    wr(2'd1, 32'h410);
    addr_q.push_back(32'h400);
    wr(2'd2, 32'h1);
    wait_done(TIMEOUT + 20, cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_done: got done=%b want 1", bus.done_o); end
    checks++; if (cyc != TIMEOUT + 1) begin failures++; $display("FAIL to_cycles: got %0d want %0d", cyc, TIMEOUT + 1); end
    checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL to_err: got %b want 1", bus.err_o); end
    rd(2'd3, d);
    checks++; if (d !== 32'h0000_0006) begin failures++; $display("FAIL to_status: got %h want 00000006", d); end
    mem_resp_en = 1'b1;
    check_drained("to");
  endtask

  task automatic test_busy_writes();
    logic [31:0] d; int cyc; bit ok;
    wr(2'd0, 32'h500);
    wr(2'd1, 32'h510);
    bus.sig_ready_i = 1'b0;
    push_range(32'h500, 32'h510);
    wr(2'd2, 32'hB);
    wait_valid(20, ok);
    wr(2'd0, 32'h900);
    wr(2'd1, 32'h520);
    wr(2'd2, 32'h41);
    rd(2'd0, d);
    checks++; if (d !== 32'h500) begin failures++; $display("FAIL busy_begin: got %h want 00000500", d); end
    rd(2'd1, d);
    checks++; if (d !== 32'h510) begin failures++; $display("FAIL busy_end: got %h want 00000510", d); end
    checks++;
    if (bus.exit_code_o !== 31'd5 || bus.busy_o !== 1'b1) begin
      failures++; $display("FAIL busy_exit: got exit %h busy %b want 5 1", bus.exit_code_o, bus.busy_o);
    end
    bus.sig_ready_i = 1'b1;
    wait_done(60, cyc, ok);
    rd(2'd3, d);
    checks++; if (d !== 32'h0004_0002) begin failures++; $display("FAIL busy_status: got %h want 00040002", d); end
    check_drained("busy");
  endtask

  task automatic test_reset_mid_dump();
    logic [31:0] d; int cyc; bit ok;
    mem_resp_en = 1'b0;
    wr(2'd0, 32'h600);
    wr(2'd1, 32'h608);
    addr_q.push_back(32'h600);
    wr(2'd2, 32'h7);
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b want 1", bus.busy_o); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_req_o, bus.sig_valid_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0 || bus.exit_code_o !== 31'd0) begin
      failures++; $display("FAIL mid_reset: got flags %b exit %h want 00000 0", {bus.mem_req_o, bus.sig_valid_o, bus.busy_o, bus.done_o, bus.err_o}, bus.exit_code_o);
    end
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mem_resp_en = 1'b1;
    @(posedge clk); #1;
    wr(2'd0, 32'h700);
    wr(2'd1, 32'h70C);
    push_range(32'h700, 32'h70C);
    wr(2'd2, 32'h5);
    wait_done(50, cyc, ok);
    rd(2'd3, d);
    checks++; if (d !== 32'h0003_0002) begin failures++; $display("FAIL post_rst_status: got %h want 00030002", d); end
    checks++; if (bus.exit_code_o !== 31'd2) begin failures++; $display("FAIL post_rst_exit: got %h want 2", bus.exit_code_o); end
    check_drained("post_rst");
  endtask

  initial begin
    test_reset();
    test_basic_dump();
    test_empty_range();
    test_backpressure();
    test_timeout();
    test_busy_writes();
    test_reset_mid_dump();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
